// File: rtl/delivery_map_scroller_pkg.sv
// Shared delivery-game definitions: scroller state encodings and default timing constants.
package delivery_map_scroller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REQ  = 2'd2
    } scroll_state_t;

    localparam int DEF_PERIOD_W        = 26;
    localparam int DEF_INIT_PERIOD     = 25000000;
    localparam int DEF_MIN_PERIOD      = 5000000;
    localparam int DEF_PERIOD_STEP     = 2500000;
    localparam int DEF_STEPS_PER_LEVEL = 16;
    localparam int DEF_MAX_LEVEL       = 8;
    localparam int DEF_LEVEL_W         = 4;
    localparam int DEF_MAP_W           = 8;

endpackage

// File: rtl/delivery_tick_divider.sv
// Loadable-terminal cycle counter: pulses tick on the last cycle of each period while enabled.
module delivery_tick_divider #(
    parameter int PERIOD_W = 26
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] count;

    assign tick = enable && !restart && (count == period - ONE);

    // restart wins over counting so a new period always starts from zero
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/delivery_map_scroller.sv
// Map-scroll timing stage: divides the clock into map steps and requests speed-ups each level.
module delivery_map_scroller
    import delivery_map_scroller_pkg::*;
#(
    parameter int PERIOD_W        = DEF_PERIOD_W,
    parameter int INIT_PERIOD     = DEF_INIT_PERIOD,
    parameter int MIN_PERIOD      = DEF_MIN_PERIOD,
    parameter int PERIOD_STEP     = DEF_PERIOD_STEP,
    parameter int STEPS_PER_LEVEL = DEF_STEPS_PER_LEVEL,
    parameter int MAX_LEVEL       = DEF_MAX_LEVEL,
    parameter int LEVEL_W         = DEF_LEVEL_W,
    parameter int MAP_W           = DEF_MAP_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                count_map,
    input  logic                get_velocity,
    output logic                velocity_ready,
    output logic                map_step,
    output logic [MAP_W-1:0]    map_pos,
    output logic [LEVEL_W-1:0]  level,
    output logic [PERIOD_W-1:0] period
);

    localparam int STEP_W = (STEPS_PER_LEVEL > 2) ? $clog2(STEPS_PER_LEVEL) : 1;

    localparam logic [PERIOD_W-1:0] INIT_P     = PERIOD_W'(INIT_PERIOD);
    localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] STEP_P     = PERIOD_W'(PERIOD_STEP);
    localparam logic [PERIOD_W:0]   FLOOR_P    = (PERIOD_W+1)'(MIN_PERIOD + PERIOD_STEP);
    localparam logic [LEVEL_W-1:0]  MAX_L      = LEVEL_W'(MAX_LEVEL);
    localparam logic [STEP_W-1:0]   LAST_STEP  = STEP_W'(STEPS_PER_LEVEL - 1);

    scroll_state_t     state;
    scroll_state_t     state_next;
    logic [STEP_W-1:0] step_cnt;
    logic              tick;
    logic              count_en;
    logic              last_step;
    logic              speed_up;

    // get_velocity takes precedence over a coincident terminal tick
    assign count_en       = (state == RUN) && count_map && !get_velocity && !clear;
    assign speed_up       = get_velocity && (state == REQ);
    assign last_step      = (step_cnt == LAST_STEP);
    assign velocity_ready = (state == REQ);

    delivery_tick_divider #(
        .PERIOD_W (PERIOD_W)
    ) u_tick_divider (
        .clock   (clock),
        .reset   (reset),
        .enable  (count_en),
        .restart (clear | get_velocity),
        .period  (period),
        .tick    (tick)
    );

    always_comb begin
        state_next = state;
        if (get_velocity) begin
            state_next = RUN;
        end else if (tick && last_step && (level < MAX_L)) begin
            state_next = REQ;
        end
    end

    // Period shrinks only on an acknowledged request, clamped to the floor without underflow
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state    <= IDLE;
            step_cnt <= '0;
            map_pos  <= '0;
            level    <= '0;
            period   <= INIT_P;
            map_step <= 1'b0;
        end else begin
            state    <= state_next;
            map_step <= tick;
            if (speed_up) begin
                if (level < MAX_L) begin
                    level <= level + LEVEL_W'(1);
                end
                if ({1'b0, period} < FLOOR_P) begin
                    period <= MIN_P;
                end else begin
                    period <= period - STEP_P;
                end
            end
            if (tick) begin
                map_pos  <= map_pos + MAP_W'(1);
                step_cnt <= last_step ? '0 : step_cnt + STEP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_delivery_map_scroller.sv
// Directed self-checking bench for delivery_map_scroller using the reduced test-plan parameters.
module tb_delivery_map_scroller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       count_map = 1'b0;
    logic       get_velocity = 1'b0;
    logic       velocity_ready;
    logic       map_step;
    logic [2:0] map_pos;
    logic [3:0] level;
    logic [3:0] period;

    int checks = 0;
    int failures = 0;

    delivery_map_scroller #(
        .PERIOD_W        (4),
        .INIT_PERIOD     (4),
        .MIN_PERIOD      (2),
        .PERIOD_STEP     (1),
        .STEPS_PER_LEVEL (3),
        .MAX_LEVEL       (2),
        .LEVEL_W         (4),
        .MAP_W           (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .clear          (clear),
        .count_map      (count_map),
        .get_velocity   (get_velocity),
        .velocity_ready (velocity_ready),
        .map_step       (map_step),
        .map_pos        (map_pos),
        .level          (level),
        .period         (period)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Apply inputs, then advance one edge; outputs are sampled 1 time unit after it
    task automatic applyStimulus(input logic rst, input logic clr, input logic cm, input logic gv);
        reset        = rst;
        clear        = clr;
        count_map    = cm;
        get_velocity = gv;
        @(posedge clock);
        #1;
    endtask

    task automatic checkAll(input string tag, input int rdy, input int stp, input int pos,
                            input int lvl, input int per);
        checkOutput({tag, ".ready"}, int'(velocity_ready), rdy);
        checkOutput({tag, ".step"}, int'(map_step), stp);
        checkOutput({tag, ".pos"}, int'(map_pos), pos);
        checkOutput({tag, ".level"}, int'(level), lvl);
        checkOutput({tag, ".period"}, int'(period), per);
    endtask

    initial begin
        int exp_pos;

        // 1: reset, clear, prepare, then basic scroll at period 4
        @(negedge clock);
        applyStimulus(1, 0, 0, 0);
        checkAll("reset", 0, 0, 0, 0, 4);
        applyStimulus(0, 1, 0, 0);
        checkAll("clear", 0, 0, 0, 0, 4);
        applyStimulus(0, 0, 0, 1);
        checkAll("prep", 0, 0, 0, 0, 4);
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("s1.step", int'(map_step), (c % 4 == 0) ? 1 : 0);
            checkOutput("s1.pos", int'(map_pos), c / 4);
        end
        checkOutput("s1.ready", int'(velocity_ready), 1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 0, 1, 0);
            checkAll("s1.frozen", 1, 0, 3, 0, 4);
        end

        // 2: acknowledge request, period drops to 3
        applyStimulus(0, 0, 1, 1);
        checkAll("s2.ack", 0, 0, 3, 1, 3);
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("s2.step", int'(map_step), (c % 3 == 0) ? 1 : 0);
            checkOutput("s2.pos", int'(map_pos), 3 + c / 3);
        end
        checkOutput("s2.ready", int'(velocity_ready), 1);

        // 3: reach level 2 (period 2), then 20 steps with no further request
        applyStimulus(0, 0, 1, 1);
        checkAll("s3.ack", 0, 0, 6, 2, 2);
        exp_pos = 6;
        for (int c = 1; c <= 40; c++) begin
            applyStimulus(0, 0, 1, 0);
            if (c % 2 == 0) exp_pos = (exp_pos + 1) % 8;
            checkAll("s3.run", 0, (c % 2 == 0) ? 1 : 0, exp_pos, 2, 2);
        end
        checkOutput("s3.wrapped_pos", int'(map_pos), 2);

        // 4: pause with tick count at 2
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 0, 0);
            checkAll("s4.paused", 0, 0, 0, 0, 4);
        end
        applyStimulus(0, 0, 1, 0);
        checkOutput("s4.resume1.step", int'(map_step), 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("s4.resume2.step", int'(map_step), 1);
        checkOutput("s4.resume2.pos", int'(map_pos), 1);

        // 5: clear while a request is pending
        for (int c = 0; c < 8; c++) applyStimulus(0, 0, 1, 0);
        checkAll("s5.pending", 1, 1, 3, 0, 4);
        applyStimulus(0, 0, 1, 1);
        for (int c = 0; c < 9; c++) applyStimulus(0, 0, 1, 0);
        checkAll("s5.pending_l1", 1, 1, 6, 1, 3);
        applyStimulus(0, 1, 1, 0);
        checkAll("s5.cleared", 0, 0, 0, 0, 4);

        // 6: get_velocity on the same edge as a terminal tick
        applyStimulus(0, 0, 0, 1);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        checkAll("s6.collide", 0, 0, 0, 0, 4);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("s6.restart.step", int'(map_step), 0);
        end
        applyStimulus(0, 0, 1, 0);
        checkOutput("s6.first.step", int'(map_step), 1);
        checkOutput("s6.first.pos", int'(map_pos), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/delivery_map_scroller.md
Name: delivery_map_scroller

Overview:
- Timing/datapath stage directly downstream of the delivery-game control unit.
- Consumes reset_out, count_map and get_velocity; produces velocity_ready back to it.
- Generates the periodic map-scroll tick and the map position, and raises speed-up requests that shorten the scroll period each level.

Parameters:
- PERIOD_W, 26, width of period and tick counter.
- INIT_PERIOD, 25000000, clock cycles per map step at level 0.
- MIN_PERIOD, 5000000, floor for the period.
- PERIOD_STEP, 2500000, period reduction per level.
- STEPS_PER_LEVEL, 16, map steps between speed-up requests.
- MAX_LEVEL, 8, level at which requests stop.
- LEVEL_W, 4, level width.
- MAP_W, 8, map position width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  game restart (driven by control-unit reset_out); synchronous.
- count_map  in  1  scrolling enabled (control-unit count_map).
- get_velocity  in  1  apply velocity / restart tick (control-unit get_velocity).
- velocity_ready  out  1  speed-up request pending (to control unit).
- map_step  out  1  one-cycle pulse per map advance.
- map_pos  out  MAP_W  current map position.
- level  out  LEVEL_W  current speed level.
- period  out  PERIOD_W  active cycles-per-step value.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All state is updated on the rising clock edge.
- Reset and clear values (identical for both):
  - tick_cnt = 0, step_cnt = 0, map_pos = 0, level = 0.
  - period = INIT_PERIOD.
  - velocity_ready = 0, map_step = 0.
- Priority per edge: reset > clear > get_velocity > counting.
- States:
  - IDLE: entered by reset/clear.
  - RUN: pending = 0.
  - REQ: pending = 1.
  - velocity_ready is the registered pending flag (REQ ⇔ velocity_ready = 1).
- get_velocity in IDLE or RUN (the preparation case):
  - tick_cnt ← 0.
  - Go to RUN; period unchanged.
- get_velocity in REQ:
  - level ← level + 1.
  - period ← max(period − PERIOD_STEP, MIN_PERIOD), computed without underflow: if period < MIN_PERIOD + PERIOD_STEP, load MIN_PERIOD.
  - tick_cnt ← 0. Go to RUN.
  - velocity_ready is low from the next cycle, so the control unit's one-cycle GET_VELOCITY state never re-triggers.
- Counting in RUN with count_map = 1:
  - tick_cnt increments each cycle.
  - When tick_cnt = period − 1:
    - tick_cnt ← 0; map_step = 1 on the next cycle, for exactly one cycle.
    - map_pos ← map_pos + 1, wrapping modulo 2^MAP_W.
    - step_cnt ← step_cnt + 1.
  - If that step makes step_cnt reach STEPS_PER_LEVEL:
    - step_cnt ← 0.
    - If level < MAX_LEVEL, go to REQ.
    - At MAX_LEVEL there is no request; step_cnt simply wraps.
- count_map = 0: all counters hold; map_step = 0. IDLE stays IDLE until get_velocity.
- REQ: tick_cnt and map_pos frozen until get_velocity or clear. count_map is ignored.
- Simultaneous get_velocity and terminal tick: get_velocity wins; no map_step and no map_pos advance that cycle.
- Clear or reset mid-REQ: the request is dropped; velocity_ready is 0 next cycle.
- Latency:
  - Request to velocity_ready: 1 cycle after the terminal tick.
  - New period: effective on the first count after get_velocity.
- Period changes only at get_velocity in REQ. Level saturates at MAX_LEVEL.

Decomposition:
- Shared delivery-game package:
  - State encodings IDLE/RUN/REQ (2-bit).
  - Default timing constants INIT_PERIOD, MIN_PERIOD, PERIOD_STEP, STEPS_PER_LEVEL, MAX_LEVEL.
  - These are kept alongside the control-unit state constants.
- One natural sub-module: delivery_tick_divider.
  - Loadable-terminal counter: inputs enable, restart, period; output tick pulse.
  - Instantiated once for tick_cnt.
- Step counter, level/period update and REQ FSM stay in the top module.

Test Plan:
Parameters for all scenarios: INIT_PERIOD=4, MIN_PERIOD=2, PERIOD_STEP=1, STEPS_PER_LEVEL=3, MAX_LEVEL=2, PERIOD_W=4, MAP_W=3.
1. Reset and basic scroll:
   - Stimulus: reset 1 cycle, clear 1 cycle, get_velocity 1 cycle, then count_map=1 for 12 cycles.
   - Required: map_step pulses every 4 cycles; map_pos = 1, 2, 3 after the pulses.
   - Required: velocity_ready = 1 one cycle after the 3rd step; map_pos frozen at 3 while pending.
2. Speed-up handshake:
   - Stimulus: from scenario 1, pulse get_velocity 1 cycle.
   - Required: level = 1, period = 3, velocity_ready = 0 the next cycle; map_step then every 3 cycles.
3. Saturation:
   - Stimulus: continue to level 2 (period = 2), then run 20 more steps.
   - Required: velocity_ready never asserts again; period stays 2; map_pos wraps 7 → 0.
4. Pause:
   - Stimulus: count_map=0 for 10 cycles mid-count with tick_cnt = 2.
   - Required: no map_step; counting resumes from tick_cnt = 2.
5. Clear during REQ:
   - Stimulus: assert clear while velocity_ready = 1.
   - Required: next cycle velocity_ready = 0, map_pos = 0, level = 0, period = 4.
6. Collision of events:
   - Stimulus: get_velocity on the same edge as a terminal tick in RUN.
   - Required: no map_step; tick_cnt = 0; map_pos unchanged.
